ddr4_v2_2_20_axi_fifo_drain: RTL and testbench
==============================================

Name: ddr4_v2_2_20_axi_fifo_drain

Overview:
- Output stage placed directly downstream of the shallow show-ahead command/data FIFO in the AXI slave.
- Pops the FIFO through its rd_en/dout/empty interface and presents the entries on a registered valid/ready master interface.
- Holds up to two entries: a head register and a skid register.
- fifo_rd_en never depends combinationally on m_ready. This breaks the timing path from the downstream consumer back into the FIFO read counter.

Parameters:
C_WIDTH, 8, data width; must equal the upstream FIFO C_WIDTH.
C_STALL_W, 16, width of the stall counter (used only with the optional feature).

Ports:
clk  input  1  main system clock.
rst_n  input  1  asynchronous active-low reset.
fifo_dout  input  C_WIDTH  upstream FIFO current head data; valid when fifo_empty=0.
fifo_empty  input  1  upstream FIFO empty flag.
fifo_rd_en  output  1  upstream FIFO pop, combinational; the FIFO advances on the clock edge.
flush  input  1  synchronous discard of all buffered entries.
m_valid  output  1  output entry valid, registered.
m_data  output  C_WIDTH  output entry, registered.
m_ready  input  1  downstream accept.
occupancy  output  2  number of entries held (0..2), registered.
stall_cnt  output  C_STALL_W  count of cycles with m_valid=1 and m_ready=0 (optional feature).

Behaviour:
- Reset (rst_n low, asynchronous): occ=0, m_valid=0, m_data=0, skid=0, stall_cnt=0. fifo_rd_en is forced to 0 for as long as rst_n is low.
- States follow occ: EMPTY(0), ONE(1), TWO(2). m_valid = (occ != 0). occupancy = occ.
- Definitions: pop = fifo_rd_en. take = m_valid & m_ready.
- fifo_rd_en = rst_n & !fifo_empty & !flush & (occ != 2). This uses registered occ only.
- EMPTY:
  - pop -> head<=fifo_dout, go to ONE.
  - no pop -> stay in EMPTY.
- ONE:
  - pop & take -> head<=fifo_dout, stay in ONE. This gives full throughput of 1 entry/cycle.
  - pop & !take -> skid<=fifo_dout, go to TWO.
  - !pop & take -> go to EMPTY.
  - neither -> hold.
- TWO:
  - take -> head<=skid, go to ONE. No pop is possible from TWO.
  - !take -> hold; m_data stable.
- Latency: 1 cycle from fifo_empty falling (with occ=0) to m_valid rising. Data is taken from fifo_dout at the popping edge.
- Ordering: strict FIFO order. Head is always older than skid.
- AXI rule: once m_valid=1, m_valid and m_data stay stable until take, unless flush is asserted.
- flush:
  - A handshake in the same cycle completes normally on the output.
  - fifo_rd_en=0 in that cycle.
  - Next cycle: occ=0, m_valid=0. Head and skid contents are don't-care.
  - flush does not empty the upstream FIFO; that FIFO's rst is the owner's responsibility.
- m_ready while m_valid=0 has no effect.
- fifo_empty toggling has no effect on buffered entries.
- Reset asserted mid-transfer: buffered entries are lost. m_valid drops asynchronously.

Optional Feature:
- Macro: DDR4_AXI_FIFO_DRAIN_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 in every cycle with m_valid & !m_ready, and saturates at all-ones.
  - It clears on reset and also on flush; clear has priority over increment.
- Undefined:
  - stall_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Reset, then FIFO holds 0x11, 0x22, 0x33 with m_ready=1 held:
  - fifo_rd_en is high 3 consecutive cycles.
  - m_data shows 0x11, 0x22, 0x33 on consecutive cycles, with m_valid high for exactly 3 cycles.
- FIFO holds 0xA1, 0xA2, 0xA3 with m_ready=0:
  - After 2 pops, occupancy=2 and fifo_rd_en=0.
  - m_data holds 0xA1 stable.
  - Raising m_ready then delivers 0xA1, 0xA2, 0xA3 in order.
- m_ready toggling 1,0,1,0 while the FIFO streams 8 entries:
  - No entry is lost or duplicated.
  - fifo_rd_en never depends on same-cycle m_ready; check by forcing m_ready with occ=1 and fifo_rd_en unchanged.
- occupancy=2 (0x5A head), assert flush with m_ready=1:
  - 0x5A is handshaken that cycle.
  - Next cycle occupancy=0, m_valid=0, and no pop occurred in the flush cycle.
- rst_n driven low asynchronously mid-cycle with occupancy=2:
  - m_valid, occupancy and fifo_rd_en go to 0 immediately.
  - After release with the FIFO non-empty, the first pop occurs on the first clock edge.
- Macro defined, C_STALL_W=4, m_valid=1 and m_ready=0 for 20 cycles:
  - stall_cnt saturates at 15.
  - flush clears it to 0.
  - Macro undefined: stall_cnt=0 throughout.

Source files
------------

// File: rtl/ddr4_v2_2_20_axi_fifo_drain_if.sv
// Registered valid/ready output bus of the AXI FIFO drain stage.
interface ddr4_v2_2_20_axi_fifo_drain_if #(
  parameter int C_WIDTH = 8
);
  logic               valid;
  logic [C_WIDTH-1:0] data;
  logic               ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ddr4_v2_2_20_axi_fifo_drain.sv
// Two-entry (head + skid) drain stage behind the show-ahead AXI FIFO.
// Optional stall counter: DDR4_AXI_FIFO_DRAIN_STALL_CNT_EN.
module ddr4_v2_2_20_axi_fifo_drain #(
  parameter int C_WIDTH   = 8,
  parameter int C_STALL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [C_WIDTH-1:0]   fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic                 flush,
  ddr4_v2_2_20_axi_fifo_drain_if.master m,
  output logic [1:0]           occupancy,
  output logic [C_STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [C_WIDTH-1:0] head, head_nxt;
  logic [C_WIDTH-1:0] skid, skid_nxt;
  logic               pop, take;

  // Pop decision uses only registered occupancy, never m.ready.
  assign fifo_rd_en = rst_n & ~fifo_empty & ~flush & (state != TWO);
  assign pop        = fifo_rd_en;
  assign take       = m.valid & m.ready;

  assign m.valid   = (state != EMPTY);
  assign m.data    = head;
  assign occupancy = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      skid  <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    case (state)
      EMPTY: if (pop) begin
        head_nxt  = fifo_dout;
        state_nxt = ONE;
      end
      ONE: begin
        if (pop && take) begin
          head_nxt = fifo_dout;
        end else if (pop) begin
          skid_nxt  = fifo_dout;
          state_nxt = TWO;
        end else if (take) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (take) begin
        head_nxt  = skid;
        state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
    // pop is already blocked by flush, so no entry is lost upstream here
    if (flush) state_nxt = EMPTY;
  end

`ifdef DDR4_AXI_FIFO_DRAIN_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (flush)
      stall_cnt <= '0;
    else if (m.valid && !m.ready && (stall_cnt != {C_STALL_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr4_v2_2_20_axi_fifo_drain.sv
// Directed bench for the AXI FIFO drain stage with a queue model of the upstream FIFO.
module tb_ddr4_v2_2_20_axi_fifo_drain;
  localparam int W  = 8;
  localparam int SW = 4;
`ifdef DDR4_AXI_FIFO_DRAIN_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          flush;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;

  int errs = 0;
  int nchk = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] exq[$];

  ddr4_v2_2_20_axi_fifo_drain_if #(.C_WIDTH(W)) m_if ();

  ddr4_v2_2_20_axi_fifo_drain #(.C_WIDTH(W), .C_STALL_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m          (m_if),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() == 0) ? '0 : fq[0];
  endtask

  task automatic push(input logic [W-1:0] v);
    fq.push_back(v);
    refresh();
  endtask

  // One clock: the modelled FIFO advances just after the edge if it was popped.
  task automatic tick();
    logic rd;
    #1;
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) void'(fq.pop_front());
    refresh();
    @(negedge clk);
  endtask

  initial begin
    int  got;
    bit  did;
    logic r0, r1;
    rst_n = 1'b0; flush = 1'b0; m_if.ready = 1'b1;
    refresh();
    repeat (2) @(negedge clk);

    // reset state, rd_en forced low while reset held
    push(8'h11); push(8'h22); push(8'h33);
    #1;
    chk("rst_valid", m_if.valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_data", m_if.data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_stall", stall_cnt, 0);

    // streaming with ready held high
    rst_n = 1'b1; #1;
    chk("t1_rd0", fifo_rd_en, 1);
    tick(); chk("t1_d0", m_if.data, 8'h11); chk("t1_v0", m_if.valid, 1); chk("t1_rd1", fifo_rd_en, 1);
    tick(); chk("t1_d1", m_if.data, 8'h22); chk("t1_v1", m_if.valid, 1); chk("t1_rd2", fifo_rd_en, 1);
    tick(); chk("t1_d2", m_if.data, 8'h33); chk("t1_v2", m_if.valid, 1); chk("t1_rd3", fifo_rd_en, 0);
    tick(); chk("t1_v3", m_if.valid, 0);

    // backpressure fills head + skid
    m_if.ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3);
    tick(); chk("t2_occ1", occupancy, 1); chk("t2_rd1", fifo_rd_en, 1);
    tick(); chk("t2_occ2", occupancy, 2); chk("t2_rd2", fifo_rd_en, 0); chk("t2_d2", m_if.data, 8'hA1);
    tick(); chk("t2_hold_occ", occupancy, 2); chk("t2_hold_d", m_if.data, 8'hA1);
    m_if.ready = 1'b1;
    tick(); chk("t2_o1", m_if.data, 8'hA2);
    tick(); chk("t2_o2", m_if.data, 8'hA3); chk("t2_o2v", m_if.valid, 1);
    tick(); chk("t2_end", occupancy, 0);

    // toggling ready with scoreboard, plus ready-independence of rd_en
    for (int i = 0; i < 8; i++) begin
      push(8'h80 + 8'(i));
      exq.push_back(8'h80 + 8'(i));
    end
    got = 0; did = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      m_if.ready = ~cyc[0];
      #1;
      if (!did && occupancy == 2'd1 && !fifo_empty) begin
        m_if.ready = 1'b0; #1; r0 = fifo_rd_en;
        m_if.ready = 1'b1; #1; r1 = fifo_rd_en;
        chk("t3_rd_one", r0, 1);
        chk("t3_rd_indep", r1, r0);
        m_if.ready = ~cyc[0]; #1;
        did = 1'b1;
      end
      if (m_if.valid && m_if.ready) begin
        if (exq.size() > 0) chk("t3_data", m_if.data, exq.pop_front());
        else chk("t3_extra", m_if.data, 32'hFFFF_FFFF);
        got++;
      end
      tick();
    end
    chk("t3_count", got, 8);
    chk("t3_did", did, 1);

    // flush with occupancy 2: same-cycle handshake, no pop
    m_if.ready = 1'b0;
    push(8'h5A); push(8'h5B); push(8'h5C);
    tick(); tick();
    chk("t4_occ2", occupancy, 2); chk("t4_head", m_if.data, 8'h5A);
    flush = 1'b1; m_if.ready = 1'b1; #1;
    chk("t4_hs", m_if.valid & m_if.ready, 1);
    chk("t4_hs_d", m_if.data, 8'h5A);
    chk("t4_rd", fifo_rd_en, 0);
    tick();
    flush = 1'b0; m_if.ready = 1'b0; #1;
    chk("t4_occ0", occupancy, 0); chk("t4_v0", m_if.valid, 0); chk("t4_fifo", fq.size(), 1);
    // flush with occ=1 and a non-empty FIFO still suppresses the pop
    tick(); chk("t4_d5c", m_if.data, 8'h5C);
    push(8'h5D); flush = 1'b1; #1;
    chk("t4_rd_fl", fifo_rd_en, 0);
    tick(); flush = 1'b0; #1;
    chk("t4_occ0b", occupancy, 0); chk("t4_fifo2", fq.size(), 1);

    // stall counter: 20 stalled cycles, then flush
    tick(); chk("t6_v", m_if.valid, 1); chk("t6_s0", stall_cnt, 0);
    repeat (5) tick();
    chk("t6_s5", stall_cnt, STALL_EN ? 5 : 0);
    repeat (15) tick();
    chk("t6_sat", stall_cnt, STALL_EN ? 15 : 0);
    chk("t6_hold", m_if.data, 8'h5D);
    flush = 1'b1; tick(); flush = 1'b0; #1;
    chk("t6_clr", stall_cnt, 0); chk("t6_occ", occupancy, 0);

    // asynchronous reset mid-cycle with occupancy 2
    push(8'h61); push(8'h62); push(8'h63);
    tick(); tick();
    chk("t5_occ2", occupancy, 2);
    #2 rst_n = 1'b0; #1;
    chk("t5_v", m_if.valid, 0); chk("t5_occ", occupancy, 0); chk("t5_rd", fifo_rd_en, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("t5_rd_rel", fifo_rd_en, 1);
    tick();
    chk("t5_d", m_if.data, 8'h63); chk("t5_occ1", occupancy, 1);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
